// File: rtl/icache_fetch_reader.sv
// icache_fetch_reader: burst reader from a 2-cycle-latency block RAM into a
// small output FIFO with valid/ready handshake.
// The first address is issued combinationally in the start cycle so the first
// word reaches out_valid three cycles after start. Further addresses are issued
// only while buffered plus in-flight words leave room in the FIFO, so no
// returning word can ever be dropped.
// Optional feature: define FETCH_READER_ABORT_EN to add the abort input.
module icache_fetch_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   length,
`ifdef FETCH_READER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] bram_addr,
  input  logic [WIDTH-1:0] bram_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int OCC_W = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [DEPTH:0]   r_remain;
  logic [DEPTH-1:0] r_next_addr, r_addr, w_issue_addr;
  logic [1:0]       r_vld, r_lst;
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem_d [FIFO_DEPTH];
  logic             r_mem_l [FIFO_DEPTH];
  logic             r_done;
  logic             w_issue, w_issue_last, w_done_set, w_accept;
  logic             w_wr, w_rd, w_credit, w_abort;
  logic [1:0]       w_inflight;
  logic [OCC_W-1:0] w_occ;

`ifdef FETCH_READER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_inflight = {1'b0, r_vld[0]} + {1'b0, r_vld[1]};
  assign w_occ      = {1'b0, r_count} + {{(OCC_W-2){1'b0}}, w_inflight};
  assign w_credit   = (w_occ < OCC_W'(FIFO_DEPTH));
  assign w_wr       = r_vld[1] & ~w_abort;
  assign out_valid  = (r_count != '0);
  assign w_rd       = out_valid & out_ready;
  assign out_data   = out_valid ? r_mem_d[r_rptr] : '0;
  assign out_last   = out_valid ? r_mem_l[r_rptr] : 1'b0;
  assign bram_addr  = w_issue ? w_issue_addr : r_addr;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, address issue and done request.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    w_issue_last = 1'b0;
    w_done_set   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_issue_last = (length == (DEPTH+1)'(1));
            w_state_nxt  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (r_remain == '0) begin
          w_state_nxt = S_DRAIN;
        end else if (w_credit) begin
          w_issue      = 1'b1;
          w_issue_last = (r_remain == (DEPTH+1)'(1));
          if (r_remain == (DEPTH+1)'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd && out_last) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
      w_done_set  = 1'b0;
      w_accept    = 1'b0;
    end
  end

  // Burst bookkeeping: remaining addresses, next address, held RAM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remain    <= '0;
      r_next_addr <= '0;
      r_addr      <= '0;
    end else begin
      if (w_accept) begin
        r_remain    <= length - (DEPTH+1)'(1);
        r_next_addr <= base_addr + DEPTH'(1);
      end else if (w_issue) begin
        r_remain    <= r_remain - (DEPTH+1)'(1);
        r_next_addr <= r_next_addr + DEPTH'(1);
      end
      if (w_issue) r_addr <= w_issue_addr;
    end
  end

  // Two-stage valid/last pipeline matching the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (w_abort) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[0], w_issue};
      r_lst <= {r_lst[0], w_issue_last};
    end
  end

  // FIFO pointers and occupancy; simultaneous write and read keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  // FIFO storage; contents are masked by out_valid so need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_d[r_wptr] <= bram_dout;
      r_mem_l[r_wptr] <= r_lst[1];
    end
  end

  // Done pulse, one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_done_set;
  end

endmodule

// File: doc/icache_fetch_reader.md
ICACHE_FETCH_READER -- requirements
Module: icache_fetch_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL match the attached block RAM word width.
REQ-002 Parameter DEPTH, default 10, address width; RAM holds 2**DEPTH words.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to begin a burst read; sampled only in IDLE.
REQ-007 base_addr  input  DEPTH  first word address of the burst; sampled with start.
REQ-008 length  input  DEPTH+1  number of words in the burst, 0 to 2**DEPTH; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse after the last word of a burst is accepted downstream.
REQ-011 bram_addr  output  DEPTH  read address to the RAM read port.
REQ-012 bram_dout  input  WIDTH  read data from the RAM read port.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-015 out_data  output  WIDTH  fetched word, in ascending address order.
REQ-016 out_last  output  1  high with out_valid on the final word of a burst.

Function
REQ-017 RAM read latency SHALL be treated as exactly 2 cycles: an address driven in cycle t returns data on bram_dout in cycle t+2; the block SHALL track in-flight reads in a 2-stage valid/last shift pipeline.
REQ-018 FSM states: IDLE, FETCH, DRAIN; IDLE->FETCH on start with length>0; FETCH->DRAIN when the last address has been issued; DRAIN->IDLE when the last word transfers, with done pulsed in the following cycle.
REQ-019 start with length=0 in IDLE SHALL produce no reads, no output, and a done pulse in the next cycle; busy stays low.
REQ-020 start while busy SHALL be ignored, with no effect on the current burst.
REQ-021 In FETCH, one address SHALL be issued per cycle only while fifo_count + in_flight < FIFO_DEPTH (credit rule); data SHALL never be dropped under any out_ready pattern.
REQ-022 Issued addresses SHALL be base_addr, base_addr+1, ... modulo 2**DEPTH; the address after 2**DEPTH-1 is 0.
REQ-023 Returned words SHALL be written to the FIFO in the cycle they arrive; a FIFO write and read in the same cycle SHALL leave fifo_count unchanged.
REQ-024 out_valid SHALL equal FIFO non-empty; out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 With out_ready held high and an empty pipeline, the first word SHALL appear on out_valid 3 cycles after the start cycle, followed by one word per cycle thereafter.
REQ-026 bram_addr SHALL hold its last value when no read is issued; non-issue cycles SHALL not be counted as in-flight.

Reset
REQ-027 On rst_n low: state IDLE; busy, done, out_valid, out_last = 0; bram_addr = 0; out_data = 0; FIFO and pipeline valids cleared, asynchronously.
REQ-028 Reset mid-burst SHALL discard all in-flight and buffered words; after release, the block SHALL be in IDLE with no further outputs until a new start.

Configuration
REQ-029 Macro FETCH_READER_ABORT_EN: when defined, an extra input abort (1 bit) exists; abort high in any state SHALL clear the FIFO and pipeline valids, return to IDLE next cycle, drop out_valid next cycle, and produce no done pulse; abort has priority over start in the same cycle.
REQ-030 Without FETCH_READER_ABORT_EN, the abort port SHALL not exist and a burst always runs to completion.

Verification
REQ-031 base_addr=0x010, length=4, out_ready=1, RAM[i]=i -> out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 3 cycles after start; out_last on 0x13; done 1 cycle later.
REQ-032 base_addr=0x3FE, length=4 (DEPTH=10) -> bram_addr sequence 0x3FE,0x3FF,0x000,0x001; data in that order.
REQ-033 length=16, out_ready toggled randomly 30% high -> all 16 words delivered in order, no loss or duplication, fifo_count+in_flight never exceeds 4.
REQ-034 length=0 start -> done pulse next cycle, out_valid never asserted; start during an active burst -> ignored.
REQ-035 rst_n pulsed low during word 3 of an 8-word burst -> outputs at reset values immediately; no residual words after release.
REQ-036 With FETCH_READER_ABORT_EN, abort asserted in the same cycle as start -> burst not started, no done pulse; abort mid-burst -> out_valid low next cycle, IDLE, no done pulse.
